spi_arbiter: RTL

Round-robin arbiter that shares one quick_spi instance between NUM_REQUESTERS independent clients. Each client has the same write/read valid-ready interface quick_spi exposes. The arbiter grants the SPI engine to one client for a complete transaction: write handshake, then read handshake. It sits between the client blocks and quick_spi, and steers data and handshakes to and from the granted client.

---
 rtl/spi_arbiter_if.sv | 50 +++++
 rtl/spi_arbiter.sv | 124 ++++++++++++
 2 files changed

// File: rtl/spi_arbiter_if.sv
// Client-side and quick_spi-side handshake bundle for spi_arbiter.
// slave = arbiter view, master = clients plus SPI engine view.
interface spi_arbiter_if #(
  parameter int NUM_REQUESTERS  = 2,
  parameter int MAX_DATA_LENGTH = 16,
  parameter int NUM_DEVICES     = 1
);
  localparam int LEN_WIDTH = $clog2(MAX_DATA_LENGTH);
  localparam int DW        = MAX_DATA_LENGTH * NUM_DEVICES;

  logic [NUM_REQUESTERS-1:0]           req_wrdata_valid_i;
  logic [NUM_REQUESTERS-1:0]           req_wrdata_ready_o;
  logic [NUM_REQUESTERS*LEN_WIDTH-1:0] req_wrdata_len_i;
  logic [NUM_REQUESTERS*DW-1:0]        req_wrdata_i;
  logic [NUM_REQUESTERS-1:0]           req_lock_i;
  logic [NUM_REQUESTERS-1:0]           req_rddata_valid_o;
  logic [NUM_REQUESTERS-1:0]           req_rddata_ready_i;
  logic [MAX_DATA_LENGTH-1:0]          req_rddata_mask_o;
  logic [DW-1:0]                       req_rddata_o;

  logic                                spi_wrdata_valid_o;
  logic                                spi_wrdata_ready_i;
  logic [LEN_WIDTH-1:0]                spi_wrdata_len_o;
  logic [DW-1:0]                       spi_wrdata_o;
  logic                                spi_rddata_valid_i;
  logic                                spi_rddata_ready_o;
  logic [MAX_DATA_LENGTH-1:0]          spi_rddata_mask_i;
  logic [DW-1:0]                       spi_rddata_i;

  logic [NUM_REQUESTERS-1:0]           grant_o;
  logic                                busy_o;

  modport slave (
    input  req_wrdata_valid_i, req_wrdata_len_i, req_wrdata_i, req_lock_i,
    input  req_rddata_ready_i,
    output req_wrdata_ready_o, req_rddata_valid_o, req_rddata_mask_o, req_rddata_o,
    output spi_wrdata_valid_o, spi_wrdata_len_o, spi_wrdata_o, spi_rddata_ready_o,
    input  spi_wrdata_ready_i, spi_rddata_valid_i, spi_rddata_mask_i, spi_rddata_i,
    output grant_o, busy_o
  );

  modport master (
    output req_wrdata_valid_i, req_wrdata_len_i, req_wrdata_i, req_lock_i,
    output req_rddata_ready_i,
    input  req_wrdata_ready_o, req_rddata_valid_o, req_rddata_mask_o, req_rddata_o,
    input  spi_wrdata_valid_o, spi_wrdata_len_o, spi_wrdata_o, spi_rddata_ready_o,
    output spi_wrdata_ready_i, spi_rddata_valid_i, spi_rddata_mask_i, spi_rddata_i,
    input  grant_o, busy_o
  );
endinterface

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one quick_spi between NUM_REQUESTERS clients.
// Optional macro SPI_ARB_LOCK_EN: req_lock_i keeps the grant across transactions.
module spi_arbiter #(
  parameter int NUM_REQUESTERS  = 2,
  parameter int MAX_DATA_LENGTH = 16,
  parameter int NUM_DEVICES     = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  spi_arbiter_if.slave  bus
);
  localparam int LEN_WIDTH = $clog2(MAX_DATA_LENGTH);
  localparam int DW        = MAX_DATA_LENGTH * NUM_DEVICES;
  localparam int GW        = $clog2(NUM_REQUESTERS);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;

  state_t                    state_reg;
  logic [GW-1:0]             grant_idx_reg;
  logic [GW-1:0]             rr_ptr_reg;
  logic [NUM_REQUESTERS-1:0] grant_reg;
  logic                      busy_reg;

  logic [GW-1:0]             winner_next;
  logic                      found_next;
  logic [GW-1:0]             rr_ptr_next;
  logic                      rd_fire;
  logic                      lock_hold;
  int                        cand;

  // Rotating priority search starting at rr_ptr.
  always_comb begin
    winner_next = '0;
    found_next  = 1'b0;
    cand        = 0;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      cand = int'(rr_ptr_reg) + i;
      if (cand >= NUM_REQUESTERS) cand = cand - NUM_REQUESTERS;
      if (!found_next && bus.req_wrdata_valid_i[cand]) begin
        found_next  = 1'b1;
        winner_next = cand[GW-1:0];
      end
    end
  end

  assign rr_ptr_next = (grant_idx_reg == GW'(NUM_REQUESTERS - 1)) ? '0 : grant_idx_reg + 1'b1;
  assign rd_fire     = (state_reg == WAIT_RD) && bus.spi_rddata_valid_i
                       && bus.req_rddata_ready_i[grant_idx_reg];

`ifdef SPI_ARB_LOCK_EN
  assign lock_hold = bus.req_lock_i[grant_idx_reg];
`else
  logic unused_lock;
  assign lock_hold   = 1'b0;
  assign unused_lock = ^bus.req_lock_i;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= IDLE;
      grant_idx_reg <= '0;
      rr_ptr_reg    <= '0;
      grant_reg     <= '0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (found_next) begin
            grant_idx_reg <= winner_next;
            grant_reg     <= NUM_REQUESTERS'(1) << winner_next;
            busy_reg      <= 1'b1;
            state_reg     <= ISSUE;
          end
        end
        ISSUE: begin
          // A withdrawn request gives the slot back without advancing rr_ptr.
          if (!bus.req_wrdata_valid_i[grant_idx_reg]) begin
            state_reg <= IDLE;
            grant_reg <= '0;
            busy_reg  <= 1'b0;
          end else if (bus.spi_wrdata_ready_i) begin
            state_reg <= WAIT_RD;
          end
        end
        WAIT_RD: begin
          if (rd_fire) begin
            if (lock_hold) begin
              state_reg <= ISSUE;
            end else begin
              state_reg  <= IDLE;
              grant_reg  <= '0;
              busy_reg   <= 1'b0;
              rr_ptr_reg <= rr_ptr_next;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          grant_reg <= '0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.spi_wrdata_valid_o = (state_reg == ISSUE) && bus.req_wrdata_valid_i[grant_idx_reg];
  assign bus.spi_wrdata_len_o   = bus.req_wrdata_len_i[grant_idx_reg*LEN_WIDTH +: LEN_WIDTH];
  assign bus.spi_wrdata_o       = bus.req_wrdata_i[grant_idx_reg*DW +: DW];
  assign bus.spi_rddata_ready_o = (state_reg == WAIT_RD) && bus.req_rddata_ready_i[grant_idx_reg];
  assign bus.req_rddata_mask_o  = bus.spi_rddata_mask_i;
  assign bus.req_rddata_o       = bus.spi_rddata_i;
  assign bus.grant_o            = grant_reg;
  assign bus.busy_o             = busy_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQUESTERS; gi++) begin : g_client
      assign bus.req_wrdata_ready_o[gi] = (state_reg == ISSUE) && (grant_idx_reg == GW'(gi))
                                          && bus.spi_wrdata_ready_i;
      assign bus.req_rddata_valid_o[gi] = (state_reg == WAIT_RD) && (grant_idx_reg == GW'(gi))
                                          && bus.spi_rddata_valid_i;
    end
  endgenerate
endmodule
